// File: rtl/sleep_ctrl.sv
// sleep_ctrl: requester-side countdown timer with a built-in one-second prescaler.
// A start/secs request arms an N-second delay; timeup is held in DONE until ack,
// start or cancel. Pause freezes the countdown, cancel aborts, start retriggers.
// Optional feature macro: SLEEP_CTRL_REMAIN_EN adds the remain output port.
module sleep_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SEC_W    = 8
) (
  input  logic             inclok,
  input  logic             rst,
  input  logic             start,
  input  logic [SEC_W-1:0] secs,
  input  logic             pause,
  input  logic             cancel,
  input  logic             ack,
  output logic             busy,
  output logic             timeup,
  output logic             tick_out
`ifdef SLEEP_CTRL_REMAIN_EN
  ,
  output logic [SEC_W-1:0] remain
`endif
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PreMax  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PreHalf = PW'(TICK_DIV / 2);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SEC_W-1:0] remain_q, remain_d;

  // State and counter registers, synchronous active-high reset.
  always_ff @(posedge inclok) begin
    if (rst) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
    end
  end

  // Next-state and counter update; priority cancel > start > pause > tick.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    if (cancel) begin
      state_d  = StIdle;
      presc_d  = '0;
      remain_d = '0;
    end else if (start) begin
      presc_d  = '0;
      remain_d = secs;
      state_d  = (secs == '0) ? StDone : StRun;
    end else begin
      unique case (state_q)
        StRun, StPause: begin
          if (pause) begin
            state_d = StPause;
          end else begin
            // Leaving PAUSE counts on the same edge so each paused cycle costs one cycle.
            state_d = StRun;
            if (presc_q == PreMax) begin
              presc_d  = '0;
              remain_d = remain_q - 1'b1;
              // Enter DONE at 1 so the counter never wraps.
              if (remain_q == SEC_W'(1)) state_d = StDone;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        StDone: begin
          if (ack) state_d = StIdle;
        end
        StIdle: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded purely from registered state and counters.
  always_comb begin
    busy     = (state_q == StRun) || (state_q == StPause);
    timeup   = (state_q == StDone);
    tick_out = busy && (presc_q >= PreHalf);
`ifdef SLEEP_CTRL_REMAIN_EN
    remain   = remain_q;
`else
    // remain_q stays internal; it still decides when DONE is entered.
`endif
  end

endmodule

// File: tb/tb_sleep_ctrl.sv
// Scoreboard bench for sleep_ctrl: directed test-plan sequences followed by
// randomized traffic, checked against a cycle-count model of the timer.
module tb_sleep_ctrl;

  localparam int unsigned TD = 4;
  localparam int unsigned SW = 8;

  logic          inclok = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] secs = '0;
  logic          pause = 1'b0;
  logic          cancel = 1'b0;
  logic          ack = 1'b0;
  logic          busy, timeup, tick_out;
  logic [SW-1:0] remain;

  sleep_ctrl #(
    .TICK_DIV(TD),
    .SEC_W   (SW)
  ) dut (
    .inclok  (inclok),
    .rst     (rst),
    .start   (start),
    .secs    (secs),
    .pause   (pause),
    .cancel  (cancel),
    .ack     (ack),
    .busy    (busy),
    .timeup  (timeup),
    .tick_out(tick_out)
`ifdef SLEEP_CTRL_REMAIN_EN
    ,
    .remain  (remain)
`endif
  );

`ifndef SLEEP_CTRL_REMAIN_EN
  assign remain = '0;
`endif

  always #5 inclok = ~inclok;

  typedef struct {
    logic          busy;
    logic          timeup;
    logic          tick;
    logic [SW-1:0] rem;
    int            id;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   step_id = 0;

  // Model: a delay is "secs*TD cycles of un-paused running"; everything else
  // (prescaler phase, remaining seconds) follows from the elapsed count.
  bit m_run = 0, m_done = 0;
  int m_secs = 0, m_el = 0;

  task automatic step(input bit r, input bit s, input int sc, input bit p,
                      input bit c, input bit a);
    exp_t e;
    @(negedge inclok);
    rst = r; start = s; secs = SW'(sc); pause = p; cancel = c; ack = a;
    @(posedge inclok);
    if (r || c) begin
      m_run = 0; m_done = 0; m_el = 0; m_secs = 0;
    end else if (s) begin
      m_secs = sc; m_el = 0;
      m_run = (sc != 0);
      m_done = (sc == 0);
    end else if (m_run) begin
      if (!p) begin
        m_el++;
        if (m_el == m_secs * TD) begin
          m_run = 0; m_done = 1; m_secs = 0; m_el = 0;
        end
      end
    end else if (m_done && a) begin
      m_done = 0;
    end
    e.busy   = m_run;
    e.timeup = m_done;
    e.tick   = m_run && ((m_el % TD) >= TD / 2);
    e.rem    = m_run ? SW'(m_secs - m_el / TD) : '0;
    e.id     = step_id++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per edge, compares just after the edge.
  always @(posedge inclok) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (busy !== e.busy || timeup !== e.timeup || tick_out !== e.tick
`ifdef SLEEP_CTRL_REMAIN_EN
          || remain !== e.rem
`endif
         ) begin
        n_err++;
        $display("FAIL step%0d outputs: got busy=%b timeup=%b tick=%b remain=%0d, want busy=%b timeup=%b tick=%b remain=%0d",
                 e.id, busy, timeup, tick_out, remain, e.busy, e.timeup, e.tick, e.rem);
      end
    end
  end

  initial begin
    bit p_lvl = 0;
    int sc;
    // 1: reset, then a 3-second delay.
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0);
    idle(14);
    step(0, 0, 0, 0, 0, 1);
    // 2: zero-second request and ack.
    step(0, 1, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1);
    idle(2);
    // 3: 2 seconds with a 5-cycle pause from cycle 3.
    step(0, 1, 2, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
    idle(8);
    step(0, 0, 0, 0, 0, 1);
    // 4: cancel mid-run, then a 1-second delay.
    step(0, 1, 5, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    step(0, 1, 1, 0, 0, 0);
    idle(6);
    step(0, 0, 0, 0, 0, 1);
    // 5: retrigger, then timeup held until ack.
    step(0, 1, 4, 0, 0, 0);
    idle(8);
    step(0, 1, 2, 0, 0, 0);
    idle(28);
    step(0, 0, 0, 0, 0, 1);
    idle(2);
    // 6: cancel beats start; reset in DONE.
    step(0, 1, 3, 0, 0, 0);
    idle(2);
    step(0, 1, 2, 0, 1, 0);
    idle(2);
    step(0, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    idle(2);
    // Randomized traffic, with pause as a bursty level.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) p_lvl = ~p_lvl;
      sc = ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 4));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0), sc, p_lvl,
           ($urandom_range(0, 119) == 0), ($urandom_range(0, 7) == 0));
    end
    @(posedge inclok);
    @(posedge inclok);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
